timer_core: RTL and testbench
=============================

Name: timer_core

Overview:
- Counting engine of the two-mode timer.
- Turns synchronized key inputs into a run/pause/done state machine and a prescaled 1/100 s count.
- Produces the MSBBinary (seconds, 0-99) and LSBBinary (hundredths, 0-99) values and the latched mode bit that feed the 7-segment encoder stage.
- Always counts upward. The downstream Reverser converts the count into countdown form when the mode bit is 1.

Parameters:
- TICK_DIV, 500000, clock cycles per 1/100 s tick (50 MHz clock); must be >= 2
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; must be >= 2

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- StartStop  input  1  raw key level, active-high; asynchronous to Clock
- Clear  input  1  raw key level, active-high; asynchronous to Clock
- ModeSel  input  1  raw switch; 0 = stopwatch, 1 = countdown
- LSBBinary  output  8  hundredths count, 0-99
- MSBBinary  output  8  seconds count, 0-99
- ModeOut  output  1  mode bit to the encoder stage
- Running  output  1  high only in RUN
- Done  output  1  high only in DONE

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-RUN):
  - state = IDLE; LSBBinary = 0; MSBBinary = 0; ModeOut = 0; Running = 0; Done = 0.
  - Prescaler = 0; all synchronizer and edge registers = 0.
- Input conditioning:
  - StartStop, Clear and ModeSel each pass through a SYNC_STAGES flip-flop chain.
  - StartStop and Clear get rising-edge detection: one registered press pulse per 0->1 transition.
  - With SYNC_STAGES = 2, the press pulse acts on the 3rd rising Clock edge after the input rises.
  - A held key produces exactly one pulse.
- State machine (all outputs registered):
  - IDLE: ModeOut follows synchronized ModeSel. Start press -> RUN, latching ModeOut.
  - RUN: prescaler counts. Start press -> PAUSE.
  - PAUSE: prescaler and counts hold. Start press -> RUN. ModeOut stays latched; ModeSel changes are ignored.
  - DONE: counts hold at 99/99. Start press is ignored.
  - Clear press in any state -> IDLE, with counts and prescaler set to 0 on the same edge.
  - If Clear and Start press occur in the same cycle, Clear wins.
- Prescaler and tick:
  - Prescaler is 0..TICK_DIV-1 and increments only in RUN.
  - At TICK_DIV-1 it returns to 0 and a tick occurs on that same edge.
  - The first tick after leaving IDLE comes TICK_DIV cycles after entering RUN.
  - A partially accumulated prescaler value is kept across PAUSE.
- Count update on tick:
  - LSBBinary increments; 99 -> 0 carries into MSBBinary.
  - Mode 0, 99/99 + tick -> 00/00 and stays in RUN (free wrap).
  - Mode 1, tick that lands on 99/99 -> DONE on the same edge; Running falls and Done rises.
  - The encoder stage displays 99/99 as 00.00 in mode 1.
- Width rules:
  - Counts never exceed 99; bits [7] are always 0 in both outputs.
  - Count arithmetic is 8-bit unsigned.
- ModeSel toggled while running has no effect until the next Clear returns the block to IDLE.

Test Plan (TICK_DIV = 4, SYNC_STAGES = 2):
1. Reset asserted mid-RUN at count 12/34 -> all outputs read 0 in the same cycle without a Clock edge; state IDLE after release.
2. ModeSel = 0, StartStop pulse, run 4*100 cycles -> MSBBinary = 1, LSBBinary = 0, Running = 1; first LSB increment exactly 4 cycles after Running rises.
3. Mode 0, preload by running to 99/99, one more tick -> 00/00, Running stays 1, Done = 0.
4. Mode 1, run to 99/99 -> Done = 1 and Running = 0 on the same edge; further StartStop presses leave counts at 99/99; Clear -> IDLE, counts 0, Done = 0.
5. Pause/resume: StartStop after 6 cycles of RUN (count 1, prescaler 2), hold 50 cycles, StartStop again -> next tick 2 cycles after resume; toggling ModeSel during PAUSE leaves ModeOut unchanged.
6. StartStop held high 1000 cycles -> single press (RUN only, no PAUSE); Clear and StartStop rising in the same cycle from RUN -> IDLE, counts 0.

Source files
------------

// File: rtl/timer_core.sv
// Counting engine of the two-mode timer: key sync/edge detect, IDLE/RUN/PAUSE/DONE control, prescaled 1/100 s count.
// Key press acts SYNC_STAGES+1 edges after the raw rise; all outputs registered, no backpressure.
module timer_core #(
    parameter int TICK_DIV    = 500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       ModeSel,
    output logic [7:0] LSBBinary,
    output logic [7:0] MSBBinary,
    output logic       ModeOut,
    output logic       Running,
    output logic       Done
);
    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 nextState;
    logic [SYNC_STAGES-1:0] startSync;
    logic [SYNC_STAGES-1:0] clearSync;
    logic [SYNC_STAGES-1:0] modeSync;
    logic                   startPrev;
    logic                   clearPrev;
    logic [PW-1:0]          prescaler;
    logic [7:0]             lsbCount;
    logic [7:0]             msbCount;
    logic                   modeLatch;
    logic                   startPress;
    logic                   clearPress;
    logic                   tick;
    logic                   lastTick;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            startSync <= '0;
            clearSync <= '0;
            modeSync  <= '0;
            startPrev <= 1'b0;
            clearPrev <= 1'b0;
        end else begin
            startSync <= {startSync[SYNC_STAGES-2:0], StartStop};
            clearSync <= {clearSync[SYNC_STAGES-2:0], Clear};
            modeSync  <= {modeSync[SYNC_STAGES-2:0], ModeSel};
            startPrev <= startSync[SYNC_STAGES-1];
            clearPrev <= clearSync[SYNC_STAGES-1];
        end
    end

    assign startPress = startSync[SYNC_STAGES-1] & ~startPrev;
    assign clearPress = clearSync[SYNC_STAGES-1] & ~clearPrev;
    assign tick       = (state == RUN) && (prescaler == PRE_MAX);
    // Countdown finishes on the tick that lands on 99/99.
    assign lastTick   = tick && modeLatch && (msbCount == 8'd99) && (lsbCount == 8'd98);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startPress) nextState = RUN;
            RUN: begin
                if (lastTick)        nextState = DONE;
                else if (startPress) nextState = PAUSE;
            end
            PAUSE:   if (startPress) nextState = RUN;
            DONE:    nextState = DONE;
            default: nextState = IDLE;
        endcase
        if (clearPress) nextState = IDLE;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            Running <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= nextState;
            Running <= (nextState == RUN);
            Done    <= (nextState == DONE);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prescaler <= '0;
            lsbCount  <= 8'd0;
            msbCount  <= 8'd0;
        end else if (clearPress) begin
            prescaler <= '0;
            lsbCount  <= 8'd0;
            msbCount  <= 8'd0;
        end else if (state == RUN) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                if (lsbCount == 8'd99) begin
                    lsbCount <= 8'd0;
                    msbCount <= (msbCount == 8'd99) ? 8'd0 : msbCount + 8'd1;
                end else begin
                    lsbCount <= lsbCount + 8'd1;
                end
            end
        end
    end

    // Mode tracks the switch only while idle; the start press edge latches it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            modeLatch <= 1'b0;
        end else if (state == IDLE) begin
            modeLatch <= modeSync[SYNC_STAGES-1];
        end
    end

    assign LSBBinary = lsbCount;
    assign MSBBinary = msbCount;
    assign ModeOut   = modeLatch;
endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core with TICK_DIV = 4, SYNC_STAGES = 2.
module tb_timer_core;
    logic       Clock;
    logic       Reset;
    logic       StartStop;
    logic       Clear;
    logic       ModeSel;
    logic [7:0] LSBBinary;
    logic [7:0] MSBBinary;
    logic       ModeOut;
    logic       Running;
    logic       Done;

    int total = 0;
    int bad   = 0;

    timer_core #(
        .TICK_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .StartStop (StartStop),
        .Clear     (Clear),
        .ModeSel   (ModeSel),
        .LSBBinary (LSBBinary),
        .MSBBinary (MSBBinary),
        .ModeOut   (ModeOut),
        .Running   (Running),
        .Done      (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int msb, input int lsb);
        check({tag, "_msb"}, {24'd0, MSBBinary}, msb);
        check({tag, "_lsb"}, {24'd0, LSBBinary}, lsb);
    endtask

    initial begin
        Reset     = 1'b1;
        StartStop = 1'b0;
        Clear     = 1'b0;
        ModeSel   = 1'b0;
        #2;
        checkCount("rst0", 0, 0);
        check("rst0_run",  {31'd0, Running}, 0);
        check("rst0_done", {31'd0, Done}, 0);
        check("rst0_mode", {31'd0, ModeOut}, 0);
        cyc(2);
        Reset = 1'b0;
        cyc(1);
        check("idle_run", {31'd0, Running}, 0);

        // Stopwatch: start press acts on the 3rd edge after the rise.
        StartStop = 1'b1;
        cyc(2);
        check("sync_lat_run", {31'd0, Running}, 0);
        cyc(1);
        check("start_run",  {31'd0, Running}, 1);
        check("start_mode", {31'd0, ModeOut}, 0);
        StartStop = 1'b0;
        cyc(3);
        checkCount("pre_tick", 0, 0);
        cyc(1);
        checkCount("first_tick", 0, 1);
        cyc(396);
        checkCount("one_sec", 1, 0);
        check("one_sec_run", {31'd0, Running}, 1);
        cyc(4536);
        checkCount("m0_1234", 12, 34);
        ModeSel = 1'b1;
        cyc(35060);
        checkCount("m0_9999", 99, 99);
        check("m0_9999_run", {31'd0, Running}, 1);
        cyc(4);
        checkCount("m0_wrap", 0, 0);
        check("m0_wrap_run",  {31'd0, Running}, 1);
        check("m0_wrap_done", {31'd0, Done}, 0);
        check("m0_mode_held", {31'd0, ModeOut}, 0);

        // Asynchronous reset mid-run at 12/34, observed between edges.
        cyc(4936);
        checkCount("pre_rst", 12, 34);
        #3;
        Reset = 1'b1;
        #1;
        checkCount("async_rst", 0, 0);
        check("async_rst_run",  {31'd0, Running}, 0);
        check("async_rst_done", {31'd0, Done}, 0);
        cyc(1);
        Reset = 1'b0;
        cyc(1);
        check("post_rst_run", {31'd0, Running}, 0);
        checkCount("post_rst", 0, 0);

        // Countdown mode runs to 99/99 and stops in DONE.
        cyc(3);
        check("idle_mode_follow", {31'd0, ModeOut}, 1);
        StartStop = 1'b1;
        cyc(3);
        check("m1_run", {31'd0, Running}, 1);
        StartStop = 1'b0;
        cyc(39995);
        checkCount("m1_pre_done", 99, 98);
        check("m1_pre_done_d", {31'd0, Done}, 0);
        cyc(1);
        checkCount("m1_done", 99, 99);
        check("m1_done_d",    {31'd0, Done}, 1);
        check("m1_done_r",    {31'd0, Running}, 0);
        check("m1_done_mode", {31'd0, ModeOut}, 1);
        StartStop = 1'b1;
        cyc(3);
        StartStop = 1'b0;
        cyc(3);
        checkCount("done_ign", 99, 99);
        check("done_ign_d", {31'd0, Done}, 1);
        Clear = 1'b1;
        cyc(3);
        checkCount("done_clr", 0, 0);
        check("done_clr_d", {31'd0, Done}, 0);
        check("done_clr_r", {31'd0, Running}, 0);
        Clear = 1'b0;

        // Pause after 6 run cycles, resume keeps the partial prescale.
        ModeSel = 1'b0;
        cyc(4);
        check("idle_mode0", {31'd0, ModeOut}, 0);
        StartStop = 1'b1;
        cyc(3);
        check("p_run", {31'd0, Running}, 1);
        StartStop = 1'b0;
        cyc(3);
        StartStop = 1'b1;
        cyc(3);
        check("paused_r", {31'd0, Running}, 0);
        checkCount("paused", 0, 1);
        StartStop = 1'b0;
        ModeSel   = 1'b1;
        cyc(50);
        checkCount("pause_hold", 0, 1);
        check("pause_mode", {31'd0, ModeOut}, 0);
        StartStop = 1'b1;
        cyc(3);
        check("resume_r", {31'd0, Running}, 1);
        StartStop = 1'b0;
        cyc(1);
        checkCount("resume_1", 0, 1);
        cyc(1);
        checkCount("resume_2", 0, 2);

        // Held key gives a single press; Clear beats a simultaneous start.
        Clear = 1'b1;
        cyc(3);
        checkCount("run_clr", 0, 0);
        check("run_clr_r", {31'd0, Running}, 0);
        Clear     = 1'b0;
        StartStop = 1'b1;
        cyc(3);
        check("held_start", {31'd0, Running}, 1);
        cyc(1000);
        check("held_run", {31'd0, Running}, 1);
        checkCount("held", 2, 50);
        StartStop = 1'b0;
        cyc(3);
        Clear     = 1'b1;
        StartStop = 1'b1;
        cyc(3);
        check("both_r", {31'd0, Running}, 0);
        check("both_d", {31'd0, Done}, 0);
        checkCount("both", 0, 0);
        cyc(3);
        check("both_hold_r", {31'd0, Running}, 0);
        Clear     = 1'b0;
        StartStop = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
